// File: rtl/vga_scanout_pkg.sv
// Shared VGA timing defaults and the flag bundle carried down the sync/blank delay chain.
// The renderer and game logic import the same visible-area constants from here.
package vga_scanout_pkg;

   localparam int DEFAULT_H_VISIBLE = 640;
   localparam int DEFAULT_H_FRONT   = 16;
   localparam int DEFAULT_H_SYNC    = 96;
   localparam int DEFAULT_H_BACK    = 48;
   localparam int DEFAULT_V_VISIBLE = 480;
   localparam int DEFAULT_V_FRONT   = 10;
   localparam int DEFAULT_V_SYNC    = 2;
   localparam int DEFAULT_V_BACK    = 33;

   localparam int COORD_W = 12;

   typedef struct packed {
      logic act;
      logic hs;
      logic vs;
   } sync_flags_t;

   // Blanked, both syncs deasserted (they are active-low).
   localparam sync_flags_t FLAGS_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1};

   function automatic logic in_window(input logic [COORD_W-1:0] val, input int lo, input int hi);
      return (val >= COORD_W'(lo)) && (val < COORD_W'(hi));
   endfunction

endpackage

// File: rtl/vga_scanout_sync_delay.sv
// Parameterised-depth shift register for the act/hs/vs flags, with an
// asynchronously loaded reset value so every stage starts out "inactive".
module sync_delay #(
   parameter int DEPTH = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] rst_val,
   input  logic [2:0] d,
   output logic [2:0] q
);

   logic [2:0] stages [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stages[i] <= rst_val;
         end
      end else begin
         stages[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            stages[i] <= stages[i-1];
         end
      end
   end

   assign q = stages[DEPTH-1];

endmodule

// File: rtl/vga_scanout.sv
// VGA raster generator: issues scan coordinates to the renderer, takes its pixel back
// PIXEL_LATENCY cycles later, and keeps colour, sync and blanking aligned at the pins.
module vga_scanout
   import vga_scanout_pkg::*;
#(
   parameter int          H_VISIBLE     = DEFAULT_H_VISIBLE,
   parameter int          H_FRONT       = DEFAULT_H_FRONT,
   parameter int          H_SYNC        = DEFAULT_H_SYNC,
   parameter int          H_BACK        = DEFAULT_H_BACK,
   parameter int          V_VISIBLE     = DEFAULT_V_VISIBLE,
   parameter int          V_FRONT       = DEFAULT_V_FRONT,
   parameter int          V_SYNC        = DEFAULT_V_SYNC,
   parameter int          V_BACK        = DEFAULT_V_BACK,
   parameter int          PIXEL_LATENCY = 1,
   parameter logic [11:0] FG_RGB        = 12'h555,
   parameter logic [11:0] BG_RGB        = 12'hFFF
) (
   input  logic        pixel_clk,
   input  logic        rst_n,
   input  logic        pixel,
   output logic [11:0] vga_x,
   output logic [11:0] vga_y,
   output logic        frame_start,
   output logic        video_active,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b
);

   localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

   logic [1:0]         rst_sync;
   logic               rst_int_n;
   logic [COORD_W-1:0] h;
   logic [COORD_W-1:0] v;
   sync_flags_t        flags0;
   sync_flags_t        flags_tap;
   sync_flags_t        flags_out;
   logic [11:0]        rgb;

   // Assertion is immediate; release is retimed so the raster starts cleanly on a clock edge.
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync[1];

   always_ff @(posedge pixel_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         h <= '0;
         v <= '0;
      end else if (h == H_LAST) begin
         h <= '0;
         v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
         h <= h + 1'b1;
      end
   end

   always_comb begin
      flags0     = FLAGS_IDLE;
      flags0.act = (h < COORD_W'(H_VISIBLE)) && (v < COORD_W'(V_VISIBLE));
      flags0.hs  = !in_window(h, H_SYNC_START, H_SYNC_END);
      flags0.vs  = !in_window(v, V_SYNC_START, V_SYNC_END);
   end

   sync_delay #(
      .DEPTH (PIXEL_LATENCY)
   ) u_sync_delay (
      .clk     (pixel_clk),
      .rst_n   (rst_int_n),
      .rst_val (FLAGS_IDLE),
      .d       (flags0),
      .q       (flags_tap)
   );

   // The chain tap lines up with the incoming pixel; one more register keeps the
   // flags in step with the registered colour.
   always_ff @(posedge pixel_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         flags_out <= FLAGS_IDLE;
         rgb       <= 12'h000;
      end else begin
         flags_out <= flags_tap;
         rgb       <= flags_tap.act ? (pixel ? FG_RGB : BG_RGB) : 12'h000;
      end
   end

   assign vga_x        = h;
   assign vga_y        = v;
   assign frame_start  = (h == '0) && (v == COORD_W'(V_VISIBLE));
   assign video_active = flags_out.act;
   assign vga_hs       = flags_out.hs;
   assign vga_vs       = flags_out.vs;
   assign vga_r        = rgb[11:8];
   assign vga_g        = rgb[7:4];
   assign vga_b        = rgb[3:0];

endmodule
